// File: rtl/fifo_uart_tx_if.sv
// Bundle of signals between the upstream FWFT FIFO, the UART transmitter and
// the serial line.
interface fifo_uart_tx_if #(
    parameter int WIDTH = 8
);
    // Handshake: d_in is valid whenever empty=0. The consumer takes the head
    // word on a rising edge and answers with a one-cycle r_en pulse in the
    // following cycle. The producer then advances the head to the next word.
    logic             empty;
    logic [WIDTH-1:0] d_in;
    logic             r_en;
    logic             tx;
    logic             busy;

    modport master (output empty, d_in, input r_en, tx, busy);
    modport slave  (input empty, d_in, output r_en, tx, busy);
endinterface

// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains a first-word-fall-through FIFO. Frames may carry
// an optional even-parity bit, and frames are sent back to back while data remains.
module fifo_uart_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0
) (
    input  logic          clk,
    input  logic          rst,
    fifo_uart_tx_if.slave bus,
    output logic [2:0]    fsm_state
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [BW-1:0]    bit_idx;
    logic [WIDTH-1:0] shreg;
    logic             par;
    logic             cnt_done;

    assign cnt_done  = (cnt == CNT_LAST);
    assign fsm_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            par      <= 1'b0;
            bus.tx   <= 1'b1;
            bus.r_en <= 1'b0;
            bus.busy <= 1'b0;
        end else begin
            bus.r_en <= 1'b0;
            case (state)
                IDLE: begin
                    cnt      <= '0;
                    bus.tx   <= 1'b1;
                    bus.busy <= 1'b0;
                    if (!bus.empty) begin
                        state    <= START;
                        shreg    <= bus.d_in;
                        par      <= ^bus.d_in;
                        bus.tx   <= 1'b0;
                        bus.busy <= 1'b1;
                        bus.r_en <= 1'b1;
                    end
                end
                START: begin
                    if (cnt_done) begin
                        // Each data bit is taken from bit 0 as its period starts.
                        cnt     <= '0;
                        bit_idx <= '0;
                        bus.tx  <= shreg[0];
                        shreg   <= shreg >> 1;
                        state   <= DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_done) begin
                        cnt <= '0;
                        if (bit_idx == BIT_LAST) begin
                            if (PARITY_EN != 0) begin
                                state  <= PARITY;
                                bus.tx <= par;
                            end else begin
                                state  <= STOP;
                                bus.tx <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            bus.tx  <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (cnt_done) begin
                        cnt    <= '0;
                        state  <= STOP;
                        bus.tx <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_done) begin
                        cnt <= '0;
                        // A waiting word starts the next frame with no idle gap.
                        if (!bus.empty) begin
                            state    <= START;
                            shreg    <= bus.d_in;
                            par      <= ^bus.d_in;
                            bus.tx   <= 1'b0;
                            bus.busy <= 1'b1;
                            bus.r_en <= 1'b1;
                        end else begin
                            state    <= IDLE;
                            bus.tx   <= 1'b1;
                            bus.busy <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
